// File: rtl/lsu_exec_pkg.sv
// Shared definitions for the load/store execution unit: memory-control encodings,
// FSM states, byte-enable constants and small decode helpers.
package lsu_exec_pkg;

  localparam int CTRL_MEM_WIDTH = 4;

  // ctrl_mem[1:0] = size (byte/half/word), ctrl_mem[2] = unsigned, ctrl_mem[3] = store
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LB  = 4'b0000;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LH  = 4'b0001;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LW  = 4'b0010;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LBU = 4'b0100;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_LHU = 4'b0101;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SB  = 4'b1000;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SH  = 4'b1001;
  localparam logic [CTRL_MEM_WIDTH-1:0] CTRL_SW  = 4'b1010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load_code(input logic [CTRL_MEM_WIDTH-1:0] c);
    return (c == CTRL_LB) || (c == CTRL_LH) || (c == CTRL_LW) ||
           (c == CTRL_LBU) || (c == CTRL_LHU);
  endfunction

  function automatic logic is_store_code(input logic [CTRL_MEM_WIDTH-1:0] c);
    return (c == CTRL_SB) || (c == CTRL_SH) || (c == CTRL_SW);
  endfunction

  function automatic logic [3:0] lane_be(input logic [CTRL_MEM_WIDTH-1:0] c,
                                         input logic [1:0] k);
    case (c)
      CTRL_LB, CTRL_LBU, CTRL_SB: lane_be = BE_BYTE0 << k;
      CTRL_LH, CTRL_LHU, CTRL_SH: lane_be = k[1] ? BE_HALF_HI : BE_HALF_LO;
      CTRL_LW, CTRL_SW:           lane_be = BE_WORD;
      default:                    lane_be = BE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_exec_load_align.sv
// Combinational load-result formatter: picks the addressed byte/half/word out of a
// memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_exec_pkg::*;
(
  input  logic [31:0]               rdata,
  input  logic [1:0]                k,
  input  logic [CTRL_MEM_WIDTH-1:0] ctrl_mem,
  output logic [31:0]               result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{k, 3'b000} +: 8];
  assign half_sel = rdata[{k[1], 4'b0000} +: 16];

  always_comb begin
    result = '0;
    case (ctrl_mem)
      CTRL_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      CTRL_LBU: result = {24'd0, byte_sel};
      CTRL_LH:  result = {{16{half_sel[15]}}, half_sel};
      CTRL_LHU: result = {16'd0, half_sel};
      CTRL_LW:  result = rdata;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_exec.sv
// Load/store execution unit: effective address, dmem req/gnt/rvalid handshake,
// store lane formatting and registered load writeback. Optional MISALIGN_TRAP_EN.
//
// state    | meaning
// IDLE     | ready for a new uop
// REQ      | dmem_req high, address/be/wdata held until dmem_gnt
// RESP     | load granted, waiting for dmem_rvalid
// DONE     | lsu_done (and wb_valid for loads) pulse, back to IDLE
module lsu_exec
  import lsu_exec_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uop_valid_in,
  input  logic                      uop_is_mem_load,
  input  logic                      uop_is_mem_store,
  input  logic [CTRL_MEM_WIDTH-1:0] ctrl_mem,
  input  logic [ADDR_WIDTH-1:0]     rs1_data,
  input  logic [ADDR_WIDTH-1:0]     imm,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [TAG_WIDTH-1:0]      rd_tag,
  output logic                      lsu_ready,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic [TAG_WIDTH-1:0]      wb_tag,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      lsu_done,
  output logic                      lsu_misalign
);

  lsu_state_t                state;
  logic [CTRL_MEM_WIDTH-1:0] ctrl_q;
  logic [1:0]                k_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic                      is_load_q;

  logic [ADDR_WIDTH-1:0]     ea;
  logic                      accept, legal_load, legal_store, legal, misalign;
  logic [DATA_WIDTH-1:0]     wdata_n;
  logic [DATA_WIDTH-1:0]     load_result;

  assign ea     = rs1_data + imm;
  assign accept = uop_valid_in && lsu_ready && (uop_is_mem_load || uop_is_mem_store);

  // Both type flags high, or a code whose class disagrees with the flag, is illegal.
  assign legal_load  = uop_is_mem_load  && !uop_is_mem_store && is_load_code(ctrl_mem);
  assign legal_store = uop_is_mem_store && !uop_is_mem_load  && is_store_code(ctrl_mem);
  assign legal       = legal_load || legal_store;

`ifdef MISALIGN_TRAP_EN
  assign misalign = legal &&
    (((ctrl_mem[1:0] == 2'b01) && ea[0]) || ((ctrl_mem[1:0] == 2'b10) && (ea[1:0] != 2'b00)));
`else
  assign misalign     = 1'b0;
  assign lsu_misalign = 1'b0;
`endif

  always_comb begin
    wdata_n = rs2_data;
    case (ctrl_mem[1:0])
      2'b00:   wdata_n = {4{rs2_data[7:0]}};
      2'b01:   wdata_n = {2{rs2_data[15:0]}};
      default: wdata_n = rs2_data;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata    (dmem_rdata),
    .k        (k_q),
    .ctrl_mem (ctrl_q),
    .result   (load_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LSU_IDLE;
      ctrl_q       <= '0;
      k_q          <= '0;
      tag_q        <= '0;
      is_load_q    <= 1'b0;
      lsu_ready    <= 1'b1;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_tag       <= '0;
      wb_data      <= '0;
      lsu_done     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      lsu_misalign <= 1'b0;
`endif
    end else begin
      lsu_done     <= 1'b0;
      wb_valid     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      lsu_misalign <= 1'b0;
`endif
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            lsu_ready  <= 1'b0;
            ctrl_q     <= ctrl_mem;
            k_q        <= ea[1:0];
            tag_q      <= rd_tag;
            is_load_q  <= legal_load;
            dmem_addr  <= {ea[ADDR_WIDTH-1:2], 2'b00};
            dmem_be    <= lane_be(ctrl_mem, ea[1:0]);
            dmem_wdata <= wdata_n;
            if (!legal || misalign) begin
              state    <= LSU_DONE;
              lsu_done <= 1'b1;
              dmem_we  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
              lsu_misalign <= misalign;
`endif
            end else begin
              state    <= LSU_REQ;
              dmem_req <= 1'b1;
              dmem_we  <= legal_store;
            end
          end
        end
        LSU_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (is_load_q) begin
              state <= LSU_RESP;
            end else begin
              state    <= LSU_DONE;
              lsu_done <= 1'b1;
            end
          end
        end
        LSU_RESP: begin
          if (dmem_rvalid) begin
            state    <= LSU_DONE;
            lsu_done <= 1'b1;
            wb_valid <= 1'b1;
            wb_tag   <= tag_q;
            wb_data  <= load_result;
          end
        end
        LSU_DONE: begin
          state     <= LSU_IDLE;
          lsu_ready <= 1'b1;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_exec.sv
// Directed self-checking bench for lsu_exec; load writebacks are checked through a
// scoreboard queue filled when load data is driven.
module tb_lsu_exec;
  import lsu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        uop_valid_in, uop_is_mem_load, uop_is_mem_store;
  logic [3:0]  ctrl_mem;
  logic [31:0] rs1_data, imm, rs2_data;
  logic [4:0]  rd_tag;
  logic        lsu_ready, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid, wb_valid, lsu_done, lsu_misalign;
  logic [4:0]  wb_tag;

  int tests = 0;
  int fails = 0;
  logic [36:0] sb[$];

  lsu_exec dut (
    .clk(clk), .reset(reset), .uop_valid_in(uop_valid_in),
    .uop_is_mem_load(uop_is_mem_load), .uop_is_mem_store(uop_is_mem_store),
    .ctrl_mem(ctrl_mem), .rs1_data(rs1_data), .imm(imm), .rs2_data(rs2_data),
    .rd_tag(rd_tag), .lsu_ready(lsu_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .lsu_done(lsu_done), .lsu_misalign(lsu_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Writeback monitor: every wb_valid pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb.size() == 0) begin
        check("wb.unexpected", {63'd0, wb_valid}, 64'd0);
      end else begin
        check("wb.tag_data", {27'd0, wb_tag, wb_data}, {27'd0, sb.pop_front()});
      end
    end
  end

  task automatic mem_op(input string name, input logic ld, input logic st,
                        input logic [3:0] ctrl, input logic [31:0] rs1, input logic [31:0] im,
                        input logic [31:0] rs2, input logic [4:0] tag,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input logic exp_req, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb,
                        input logic exp_mis);
    logic [31:0] ea, exp_addr;
    ea       = rs1 + im;
    exp_addr = {ea[31:2], 2'b00};
    check({name, ".ready"}, {63'd0, lsu_ready}, 64'd1);
    uop_valid_in = 1'b1; uop_is_mem_load = ld; uop_is_mem_store = st;
    ctrl_mem = ctrl; rs1_data = rs1; imm = im; rs2_data = rs2; rd_tag = tag;
    tick();
    uop_valid_in = 1'b0; uop_is_mem_load = 1'b0; uop_is_mem_store = 1'b0;
    check({name, ".busy"}, {63'd0, lsu_ready}, 64'd0);
    if (exp_req) begin
      check({name, ".req"}, {27'd0, dmem_req, dmem_we, dmem_addr, dmem_be},
            {27'd0, 1'b1, st, exp_addr, exp_be});
      if (st) check({name, ".wdata"}, {32'd0, dmem_wdata}, {32'd0, exp_wdata});
      for (int i = 0; i < gnt_dly; i++) begin
        tick();
        check({name, ".hold"}, {27'd0, dmem_req, dmem_we, dmem_addr, dmem_be},
              {27'd0, 1'b1, st, exp_addr, exp_be});
      end
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check({name, ".req_drop"}, {63'd0, dmem_req}, 64'd0);
      if (ld) begin
        for (int i = 0; i < rv_dly; i++) begin
          check({name, ".wait"}, {62'd0, lsu_done, wb_valid}, 64'd0);
          tick();
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        sb.push_back({tag, exp_wb});
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
      end
      check({name, ".done"}, {61'd0, lsu_done, wb_valid, lsu_misalign},
            {61'd0, 1'b1, ld, 1'b0});
    end else begin
      check({name, ".skip"}, {60'd0, dmem_req, lsu_done, lsu_misalign, wb_valid},
            {60'd0, 1'b0, 1'b1, exp_mis, 1'b0});
    end
    tick();
    check({name, ".after"}, {60'd0, lsu_done, wb_valid, lsu_misalign, lsu_ready},
          {60'd0, 4'b0001});
  endtask

  initial begin
    reset = 1'b1;
    uop_valid_in = 1'b0; uop_is_mem_load = 1'b0; uop_is_mem_store = 1'b0;
    ctrl_mem = '0; rs1_data = '0; imm = '0; rs2_data = '0; rd_tag = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    check("reset.ctrl", {58'd0, lsu_ready, dmem_req, dmem_we, wb_valid, lsu_done, lsu_misalign},
          {58'd0, 6'b100000});
    check("reset.data", {28'd0, dmem_addr, dmem_be}, 64'd0);
    check("reset.wb", {27'd0, wb_tag, wb_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    mem_op("sw",  0, 1, CTRL_SW,  32'h100, 32'h4, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0,
           1, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    mem_op("lb",  1, 0, CTRL_LB,  32'h200, 32'h3, 32'h0, 5'd7, 0, 0, 32'h80FF_1234,
           1, 4'b1000, 32'h0, 32'hFFFF_FF80, 0);
    mem_op("lbu", 1, 0, CTRL_LBU, 32'h200, 32'h3, 32'h0, 5'd9, 0, 0, 32'h80FF_1234,
           1, 4'b1000, 32'h0, 32'h0000_0080, 0);
    mem_op("lh",  1, 0, CTRL_LH,  32'h100, 32'h2, 32'h0, 5'd12, 3, 2, 32'h8001_0000,
           1, 4'b1100, 32'h0, 32'hFFFF_8001, 0);
    mem_op("sb",  0, 1, CTRL_SB,  32'h0, 32'h1, 32'h0000_00AB, 5'd0, 1, 0, 32'h0,
           1, 4'b0010, 32'hABAB_ABAB, 32'h0, 0);
    mem_op("sh",  0, 1, CTRL_SH,  32'h10, 32'hFFFF_FFF2, 32'h1234_5678, 5'd0, 0, 0, 32'h0,
           1, 4'b1100, 32'h5678_5678, 32'h0, 0);
    mem_op("lhu", 1, 0, CTRL_LHU, 32'h40, 32'h0, 32'h0, 5'd31, 0, 1, 32'h1234_F00D,
           1, 4'b0011, 32'h0, 32'h0000_F00D, 0);
    mem_op("bad_code", 1, 0, 4'b0011, 32'h40, 32'h0, 32'h0, 5'd3, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 32'h0, 0);
    mem_op("both", 1, 1, CTRL_LW, 32'h40, 32'h0, 32'h0, 5'd4, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    mem_op("lw_mis", 1, 0, CTRL_LW, 32'h100, 32'h2, 32'h0, 5'd5, 0, 0, 32'h0,
           0, 4'b0000, 32'h0, 32'h0, 1);
`else
    mem_op("lw_mis", 1, 0, CTRL_LW, 32'h100, 32'h2, 32'h0, 5'd5, 0, 0, 32'h1122_3344,
           1, 4'b1111, 32'h0, 32'h1122_3344, 0);
`endif

    // Reset during RESP abandons the load; a stray rvalid afterwards is ignored.
    uop_valid_in = 1'b1; uop_is_mem_load = 1'b1; ctrl_mem = CTRL_LW;
    rs1_data = 32'h300; imm = 32'h0; rd_tag = 5'd6;
    tick();
    uop_valid_in = 1'b0; uop_is_mem_load = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid.async", {60'd0, dmem_req, lsu_ready, lsu_done, wb_valid}, {60'd0, 4'b0100});
    @(negedge clk);
    reset = 1'b0;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check("rst_mid.no_wb", {61'd0, wb_valid, lsu_done, lsu_ready}, {61'd0, 3'b001});
    tick();
    check("rst_mid.idle", {62'd0, wb_valid, lsu_ready}, {62'd0, 2'b01});

    mem_op("lw", 1, 0, CTRL_LW, 32'h8, 32'h8, 32'h0, 5'd17, 0, 0, 32'hCAFE_F00D,
           1, 4'b1111, 32'h0, 32'hCAFE_F00D, 0);

    tick();
    check("sb.empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_exec.md
Name: lsu_exec

Overview:
- Load/store execution unit that consumes the memory-control uop emitted by the ALU control decoder.
- Computes the effective address, drives the data-memory request/grant/response handshake, and formats store byte-lanes and load results.
- Returns a registered writeback to the register-file stage.
- Sits in the execute stage, in parallel with the adder, logic and branch units.

Parameters:
- ADDR_WIDTH, 32, effective/memory address width.
- DATA_WIDTH, 32, data width; fixed at 32 for RV32I.
- TAG_WIDTH, 5, destination register tag carried to writeback.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high; clears all state.
- uop_valid_in  in  1  uop present.
- uop_is_mem_load  in  1  load uop.
- uop_is_mem_store  in  1  store uop.
- ctrl_mem  in  CTRL_MEM_WIDTH  CTRL_LB/LH/LW/LBU/LHU/SB/SH/SW encoding.
- rs1_data  in  32  base address.
- imm  in  32  sign-extended offset.
- rs2_data  in  32  store data.
- rd_tag  in  TAG_WIDTH  load destination.
- lsu_ready  out  1  high only in IDLE; a uop is accepted when uop_valid_in & lsu_ready & (load|store).
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_WIDTH  word-aligned address ({ea[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data word.
- wb_valid  out  1  one-cycle pulse, load result.
- wb_tag  out  TAG_WIDTH  result tag.
- wb_data  out  32  extended load data.
- lsu_done  out  1  one-cycle pulse at completion of any accepted uop.
- lsu_misalign  out  1  one-cycle pulse with lsu_done (MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- Reset values:
  - All outputs 0 except lsu_ready=1.
  - FSM in IDLE.
  - Capture registers cleared.
- FSM: IDLE -> REQ -> (load) RESP -> DONE -> IDLE; (store) DONE -> IDLE.
- IDLE, on accept:
  - Register ea = rs1_data + imm (mod 2^32), plus ctrl_mem, rs2_data, rd_tag.
  - Go to REQ.
- Accepts with ctrl_mem not matching any load/store code:
  - Go directly to DONE; no memory request; lsu_done pulses; wb_valid stays 0.
- uop_is_mem_load and uop_is_mem_store both high: treat as illegal, identical to an unknown code.
- REQ:
  - dmem_req=1, with addr/be/wdata/we held stable until dmem_gnt.
  - On gnt: load -> RESP; store -> DONE.
  - dmem_req drops the cycle after gnt.
- RESP:
  - Wait for dmem_rvalid; an rvalid in the same cycle as gnt is not allowed by the protocol.
  - Capture formatted data; go to DONE.
- DONE:
  - lsu_done=1, and wb_valid=1 for loads, for exactly one cycle; then IDLE.
- Byte enables / store data, with k = ea[1:0]:
  - SB: be = 1<<k, wdata = {4{rs2[7:0]}}.
  - SH: be = k[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
  - Loads use be of the same shape.
- Load extraction:
  - LB/LBU: byte rdata[8k+:8], sign-/zero-extended.
  - LH/LHU: half rdata[16*k[1]+:16], sign-/zero-extended.
  - LW: whole word.
- Minimum latency, accept at cycle T with gnt immediate:
  - Store: lsu_done at T+2.
  - Load with rvalid at T+2: wb_valid at T+3.
- Unbounded gnt/rvalid stall: hold state; no timeout.
- Reset asserted mid-transaction: dmem_req and all pulses drop immediately (async); the in-flight access is abandoned; a later rvalid in IDLE is ignored.
- New uop_valid_in while busy: not accepted (lsu_ready=0); the upstream holds it.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned uops (LH/LHU/SH with ea[0]=1; LW/SW with ea[1:0]!=0) skip REQ and go directly to DONE.
  - lsu_done=1 and lsu_misalign=1 together; wb_valid=0; no memory request.
- MISALIGN_TRAP_EN undefined:
  - Offending low address bits are ignored: halfword uses k[1], word uses lane 0.
  - The access proceeds normally; lsu_misalign is tied 0.

Decomposition:
- Shared execution parameter header holds:
  - CTRL_MEM_WIDTH and the CTRL_LB..CTRL_SW encodings.
  - FSM state localparams LSU_IDLE/LSU_REQ/LSU_RESP/LSU_DONE.
  - Byte-enable constants.
- One natural sub-module: lsu_load_align, purely combinational (rdata, k, ctrl_mem -> 32-bit extended result). Reused by future cache fill logic.

Test Plan:
- SW, rs1=0x100, imm=4, rs2=0xDEADBEEF, gnt immediate -> dmem_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1; lsu_done at T+2.
- LB, ea=0x203, rdata=0x80FF_1234 -> be=1000, wb_data=0xFFFFFF80, wb_tag echoed; LBU same -> wb_data=0x00000080.
- LH, ea=0x102, rdata=0x8001_0000, gnt delayed 3 cycles, rvalid 2 cycles later -> req held stable through the stall; wb_data=0xFFFF8001, single wb_valid pulse.
- SB, ea=0x001, rs2=0x000000AB -> be=0010, wdata=0xABABABAB.
- Reset asserted in RESP -> dmem_req=0, lsu_ready=1 immediately; a subsequent rvalid produces no wb_valid.
- LW, ea=0x102: with MISALIGN_TRAP_EN -> no dmem_req, lsu_done and lsu_misalign pulse at T+1; without -> dmem_addr=0x100, be=1111, normal completion.
